// File: rtl/snow64_scalar_data_shifter_pipe.sv
// snow64_scalar_data_shifter_pipe: 2-stage scalar <-> LAR-line extract/merge shifter with valid/ready flow control
//  Optional feature macro: SNOW64_SCALAR_DATA_SHIFTER_SIGN_EXTEND_EN (signed reads sign-extend when defined)
//  Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   in_valid/in_ready                   request handshake (in_ready is combinational)
//   in_is_write, in_is_signed           operation select, read sign-extension request
//   in_int_type_size                    element size 0:8b 1:16b 2:32b 3:64b
//   in_data_offset                      byte offset of the element within the line
//   in_lar_data, in_scalar              source/target line, value to insert on writes
//   out_valid/out_ready                 result handshake
//   out_is_write, out_misaligned        echoed operation, offset had its low bits cleared
//   out_scalar, out_lar_data            read result, merged line (each 0 for the other operation)
module snow64_scalar_data_shifter_pipe #(
  parameter int LAR_DATA_WIDTH = 256,
  parameter int SCALAR_WIDTH = 64,
  localparam int OFFSET_WIDTH = $clog2(LAR_DATA_WIDTH / 8)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_is_write,
  input  logic                      in_is_signed,
  input  logic [1:0]                in_int_type_size,
  input  logic [OFFSET_WIDTH-1:0]   in_data_offset,
  input  logic [LAR_DATA_WIDTH-1:0] in_lar_data,
  input  logic [SCALAR_WIDTH-1:0]   in_scalar,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_is_write,
  output logic [SCALAR_WIDTH-1:0]   out_scalar,
  output logic [LAR_DATA_WIDTH-1:0] out_lar_data,
  output logic                      out_misaligned
);
  localparam int SHIFT_WIDTH = OFFSET_WIDTH + 3;
  logic                      s1_valid_q, s1_valid_d;
  logic                      s1_is_write_q, s1_is_write_d;
  logic                      s1_is_signed_q, s1_is_signed_d;
  logic [1:0]                s1_size_q, s1_size_d;
  logic [SHIFT_WIDTH-1:0]    s1_shift_q, s1_shift_d;
  logic                      s1_mis_q, s1_mis_d;
  logic [LAR_DATA_WIDTH-1:0] s1_lar_q, s1_lar_d;
  logic [SCALAR_WIDTH-1:0]   s1_scalar_q, s1_scalar_d;
  logic                      s2_valid_q, s2_valid_d;
  logic                      s2_is_write_q, s2_is_write_d;
  logic [SCALAR_WIDTH-1:0]   s2_scalar_q, s2_scalar_d;
  logic [LAR_DATA_WIDTH-1:0] s2_lar_q, s2_lar_d;
  logic                      s2_mis_q, s2_mis_d;
  logic                      adv1, adv2;
  logic [OFFSET_WIDTH-1:0]   eff_off;
  logic [LAR_DATA_WIDTH-1:0] mask_w, wr_line;
  logic [SCALAR_WIDTH-1:0]   mask_s, rd_raw, rd_val;
`ifdef SNOW64_SCALAR_DATA_SHIFTER_SIGN_EXTEND_EN
  logic                      rd_sign;
`else
  logic                      unused_signed;
  assign unused_signed = s1_is_signed_q;
`endif
  assign adv2 = !s2_valid_q || out_ready;
  assign adv1 = !s1_valid_q || adv2;
  assign in_ready = adv1;
  assign out_valid = s2_valid_q;
  assign out_is_write = s2_is_write_q;
  assign out_scalar = s2_scalar_q;
  assign out_lar_data = s2_lar_q;
  assign out_misaligned = s2_mis_q;
  assign eff_off = in_data_offset & ~OFFSET_WIDTH'((32'd1 << in_int_type_size) - 32'd1);
  // Element mask built in line width so the write path can reuse it after shifting.
  assign mask_w = ~({LAR_DATA_WIDTH{1'b1}} << (32'd8 << s1_size_q));
  assign mask_s = mask_w[SCALAR_WIDTH-1:0];
  assign rd_raw = SCALAR_WIDTH'(s1_lar_q >> s1_shift_q) & mask_s;
`ifdef SNOW64_SCALAR_DATA_SHIFTER_SIGN_EXTEND_EN
  // Top element bit is the single bit where the mask differs from itself shifted right by one.
  assign rd_sign = s1_is_signed_q && |(rd_raw & (mask_s ^ (mask_s >> 1)));
  assign rd_val = rd_raw | ({SCALAR_WIDTH{rd_sign}} & ~mask_s);
`else
  assign rd_val = rd_raw;
`endif
  assign wr_line = (s1_lar_q & ~(mask_w << s1_shift_q))
                 | ((LAR_DATA_WIDTH'(s1_scalar_q) & mask_w) << s1_shift_q);
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_is_write_d = s1_is_write_q;
    s1_is_signed_d = s1_is_signed_q;
    s1_size_d = s1_size_q;
    s1_shift_d = s1_shift_q;
    s1_mis_d = s1_mis_q;
    s1_lar_d = s1_lar_q;
    s1_scalar_d = s1_scalar_q;
    if (adv1) s1_valid_d = in_valid;
    if (adv1 && in_valid) begin
      s1_is_write_d = in_is_write;
      s1_is_signed_d = in_is_signed;
      s1_size_d = in_int_type_size;
      s1_shift_d = {eff_off, 3'b000};
      s1_mis_d = in_data_offset != eff_off;
      s1_lar_d = in_lar_data;
      s1_scalar_d = in_scalar;
    end
  end
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_is_write_d = s2_is_write_q;
    s2_scalar_d = s2_scalar_q;
    s2_lar_d = s2_lar_q;
    s2_mis_d = s2_mis_q;
    if (adv2) s2_valid_d = s1_valid_q;
    if (adv2 && s1_valid_q) begin
      s2_is_write_d = s1_is_write_q;
      s2_scalar_d = s1_is_write_q ? '0 : rd_val;
      s2_lar_d = s1_is_write_q ? wr_line : '0;
      s2_mis_d = s1_mis_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_is_write_q <= 1'b0;
      s1_is_signed_q <= 1'b0;
      s1_size_q <= '0;
      s1_shift_q <= '0;
      s1_mis_q <= 1'b0;
      s1_lar_q <= '0;
      s1_scalar_q <= '0;
      s2_valid_q <= 1'b0;
      s2_is_write_q <= 1'b0;
      s2_scalar_q <= '0;
      s2_lar_q <= '0;
      s2_mis_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_is_write_q <= s1_is_write_d;
      s1_is_signed_q <= s1_is_signed_d;
      s1_size_q <= s1_size_d;
      s1_shift_q <= s1_shift_d;
      s1_mis_q <= s1_mis_d;
      s1_lar_q <= s1_lar_d;
      s1_scalar_q <= s1_scalar_d;
      s2_valid_q <= s2_valid_d;
      s2_is_write_q <= s2_is_write_d;
      s2_scalar_q <= s2_scalar_d;
      s2_lar_q <= s2_lar_d;
      s2_mis_q <= s2_mis_d;
    end
  end
endmodule

// File: tb/tb_snow64_scalar_data_shifter_pipe.sv
// tb_snow64_scalar_data_shifter_pipe: scoreboard bench for the scalar/LAR shifter pipe
module tb_snow64_scalar_data_shifter_pipe;
  localparam int L = 256;
  localparam int S = 64;
  typedef struct packed {
    logic         w;
    logic         sg;
    logic [1:0]   sz;
    logic [4:0]   off;
    logic [L-1:0] lar;
    logic [S-1:0] sc;
  } req_t;
  typedef struct packed {
    logic         w;
    logic [S-1:0] sc;
    logic [L-1:0] lar;
    logic         mis;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_is_write = 1'b0, in_is_signed = 1'b0;
  logic [1:0] in_int_type_size = '0;
  logic [4:0] in_data_offset = '0;
  logic [L-1:0] in_lar_data = '0;
  logic [S-1:0] in_scalar = '0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, out_is_write, out_misaligned;
  logic [S-1:0] out_scalar;
  logic [L-1:0] out_lar_data;
  req_t reqq[$];
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  logic stall_prev = 1'b0;
  logic [321:0] held = '0;
  always #5 clk = ~clk;
  snow64_scalar_data_shifter_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_write(in_is_write), .in_is_signed(in_is_signed),
    .in_int_type_size(in_int_type_size), .in_data_offset(in_data_offset),
    .in_lar_data(in_lar_data), .in_scalar(in_scalar), .out_valid(out_valid),
    .out_ready(out_ready), .out_is_write(out_is_write), .out_scalar(out_scalar),
    .out_lar_data(out_lar_data), .out_misaligned(out_misaligned)
  );
  task automatic check(string tag, logic [383:0] got, logic [383:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(req_t r);
    exp_t e;
    int n, eff;
    n = 1 << r.sz;
    eff = int'(r.off) & ~(n - 1);
    e.w = r.w;
    e.mis = eff != int'(r.off);
    e.sc = '0;
    e.lar = '0;
    if (r.w) begin
      e.lar = r.lar;
      for (int i = 0; i < n; i++) e.lar[(eff + i) * 8 +: 8] = r.sc[i * 8 +: 8];
    end else begin
      for (int i = 0; i < n; i++) e.sc[i * 8 +: 8] = r.lar[(eff + i) * 8 +: 8];
`ifdef SNOW64_SCALAR_DATA_SHIFTER_SIGN_EXTEND_EN
      if (r.sg && e.sc[n * 8 - 1]) for (int i = n; i < 8; i++) e.sc[i * 8 +: 8] = 8'hFF;
`endif
    end
    return e;
  endfunction
  function automatic logic [L-1:0] rand_lar();
    logic [L-1:0] v;
    for (int i = 0; i < L / 32; i++) v[i * 32 +: 32] = $urandom;
    return v;
  endfunction
  task automatic push_req(logic w, logic sg, logic [1:0] sz, logic [4:0] off, logic [L-1:0] lar, logic [S-1:0] sc);
    req_t r;
    r.w = w; r.sg = sg; r.sz = sz; r.off = off; r.lar = lar; r.sc = sc;
    reqq.push_back(r);
  endtask
  task automatic step(logic ordy);
    exp_t e;
    @(negedge clk);
    if (stall_prev) check("hold", {out_is_write, out_misaligned, out_scalar, out_lar_data}, held);
    out_ready = ordy;
    if (reqq.size() != 0) begin
      in_valid = 1'b1;
      in_is_write = reqq[0].w;
      in_is_signed = reqq[0].sg;
      in_int_type_size = reqq[0].sz;
      in_data_offset = reqq[0].off;
      in_lar_data = reqq[0].lar;
      in_scalar = reqq[0].sc;
    end else in_valid = 1'b0;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_out", 1, 0);
      else begin
        e = sb.pop_front();
        check("out_is_write", out_is_write, e.w);
        check("out_misaligned", out_misaligned, e.mis);
        check("out_scalar", out_scalar, e.sc);
        check("out_lar_data", out_lar_data, e.lar);
      end
    end
    if (!in_ready) check("in_ready_low_cause", {out_valid, out_ready}, 2'b10);
    if (in_valid && in_ready) sb.push_back(model(reqq.pop_front()));
    stall_prev = out_valid && !out_ready;
    held = {out_is_write, out_misaligned, out_scalar, out_lar_data};
    @(posedge clk);
  endtask
  // mode 0: out_ready always 1; mode 1: 1,0,0,1 pattern; mode 2: random
  task automatic run(int mode, int budget);
    int cyc = 0;
    logic r;
    while ((reqq.size() != 0 || sb.size() != 0) && cyc < budget) begin
      r = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
      step(r);
      cyc++;
    end
    check("drain_scoreboard", sb.size(), 0);
    check("drain_requests", reqq.size(), 0);
  endtask
  initial begin
    logic [L-1:0] line;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_scalar", out_scalar, 0);
    check("rst_out_lar_data", out_lar_data, 0);
    check("rst_out_is_write", out_is_write, 0);
    check("rst_out_misaligned", out_misaligned, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("in_ready_after_rst", in_ready, 1);
    for (int k = 0; k < 32; k++) line[k * 8 +: 8] = 8'(k);
    push_req(1'b0, 1'b0, 2'd1, 5'd6, line, '0);
    run(0, 20);
    push_req(1'b1, 1'b0, 2'd2, 5'd5, '1, 64'hDEADBEEF);
    run(0, 20);
    line = '0;
    line[255:248] = 8'h80;
    push_req(1'b0, 1'b1, 2'd0, 5'd31, line, '0);
    run(0, 20);
    for (int i = 0; i < 8; i++)
      push_req(1'(i % 2), 1'b1, 2'(i % 4), 5'($urandom_range(0, 31)), rand_lar(), {$urandom, $urandom});
    run(1, 200);
    for (int i = 0; i < 4; i++) push_req(1'b0, 1'b0, 2'd3, 5'd8, rand_lar(), '0);
    step(1'b0);
    step(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    in_valid = 1'b0;
    reqq.delete();
    sb.delete();
    stall_prev = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", out_valid, 0);
    end
    for (int i = 0; i < 60; i++)
      push_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               5'($urandom_range(0, 31)), rand_lar(), {$urandom, $urandom});
    run(2, 2000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
